// File: rtl/ad4003_pkg.sv
// Shared constants and types for the AD4003 acquisition chain.
// Holds the conversion width, the reader FSM states and the lane slicing helper.
package ad4003_pkg;

  localparam int AD4003_DATA_BITS = 18;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_SHIFT = 1'b1
  } rd_state_e;

  // Low bit index of a lane inside a packed multi-lane word.
  function automatic int lane_lo(input int lane, input int bits);
    return lane * bits;
  endfunction

endpackage

// File: rtl/ad4003_lane_shifter.sv
// One SDO lane: an MSB-first shift register, advanced while the reader FSM shifts.
module ad4003_lane_shifter #(
  parameter int DATA_BITS = 18
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_shift,
  input  logic                 i_sdo,
  output logic [DATA_BITS-1:0] o_shreg
);

  logic [DATA_BITS-1:0] r_shreg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg <= '0;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[DATA_BITS-2:0], i_sdo};
    end
  end

  assign o_shreg = r_shreg;

endmodule

// File: rtl/ad4003_sdo_reader.sv
// Deserialises all AD4003 SDO lanes inside the reader-enable window and hands each
// complete frame off as one wide word over valid/ready, flagging bad and overrun frames.
module ad4003_sdo_reader
  import ad4003_pkg::*;
#(
  parameter int N_CH      = 48,
  parameter int DATA_BITS = AD4003_DATA_BITS,
  parameter int CNT_W     = 16
) (
  input  logic                      adc_read_clk,
  input  logic                      rst_n,
  input  logic                      reader_en_sync,
  input  logic [N_CH-1:0]           adc_sdo,
  output logic [N_CH*DATA_BITS-1:0] adc_data,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic [CNT_W-1:0]          frame_cnt,
  output logic [CNT_W-1:0]          overrun_cnt,
  output logic                      frame_err,
  input  logic                      err_clr
);

  localparam int                BC_W    = $clog2(DATA_BITS + 1);
  localparam logic [BC_W-1:0]   BC_FULL = BC_W'(DATA_BITS);

  logic [N_CH-1:0]           r_sdo_q;
  logic                      r_en_q;
  rd_state_e                 r_state;
  logic [BC_W-1:0]           r_bit_cnt;
  logic                      r_long;
  logic [N_CH*DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic [CNT_W-1:0]          r_frame_cnt;
  logic [CNT_W-1:0]          r_ovr_cnt;
  logic                      r_err;

  logic                      w_shift;
  logic                      w_end;
  logic                      w_good;
  logic                      w_bad;
  logic                      w_ovr;
  logic [N_CH*DATA_BITS-1:0] w_shreg;

  // Input stage: IOB flops keep enable and data aligned.
  always_ff @(posedge adc_read_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sdo_q <= '0;
      r_en_q  <= 1'b0;
    end else begin
      r_sdo_q <= adc_sdo;
      r_en_q  <= reader_en_sync;
    end
  end

  assign w_shift = r_en_q && ((r_state == RD_IDLE) || (r_bit_cnt < BC_FULL));
  assign w_end   = (r_state == RD_SHIFT) && !r_en_q;
  assign w_good  = w_end && (r_bit_cnt == BC_FULL) && !r_long;
  assign w_bad   = w_end && !w_good;
  assign w_ovr   = w_good && r_valid && !data_ready;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    ad4003_lane_shifter #(
      .DATA_BITS(DATA_BITS)
    ) u_lane (
      .i_clk  (adc_read_clk),
      .i_rst_n(rst_n),
      .i_shift(w_shift),
      .i_sdo  (r_sdo_q[g]),
      .o_shreg(w_shreg[lane_lo(g, DATA_BITS) +: DATA_BITS])
    );
  end

  always_ff @(posedge adc_read_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RD_IDLE;
      r_bit_cnt <= '0;
      r_long    <= 1'b0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          r_long <= 1'b0;
          if (r_en_q) begin
            r_bit_cnt <= BC_W'(1);
            r_state   <= RD_SHIFT;
          end else begin
            r_bit_cnt <= '0;
          end
        end
        RD_SHIFT: begin
          if (r_en_q) begin
            if (r_bit_cnt < BC_FULL) r_bit_cnt <= r_bit_cnt + 1'b1;
            else                     r_long    <= 1'b1;
          end else begin
            r_bit_cnt <= '0;
            r_long    <= 1'b0;
            r_state   <= RD_IDLE;
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  // Hand-off: a latch in the same cycle as an accept keeps valid high without overrun.
  always_ff @(posedge adc_read_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_cnt <= '0;
      r_ovr_cnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_good) begin
        r_data      <= w_shreg;
        r_valid     <= 1'b1;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end

      if (err_clr)                         r_ovr_cnt <= w_ovr ? CNT_W'(1) : '0;
      else if (w_ovr && (r_ovr_cnt != '1)) r_ovr_cnt <= r_ovr_cnt + 1'b1;

      if (w_bad)        r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign adc_data    = r_data;
  assign data_valid  = r_valid;
  assign frame_cnt   = r_frame_cnt;
  assign overrun_cnt = r_ovr_cnt;
  assign frame_err   = r_err;

endmodule
